// File: rtl/faux_sata_host_phy.sv
// Host-side SATA PHY out-of-band and alignment sequencer for a simulated link.
// Runs COMRESET/COMWAKE, then dialtone/ALIGN bring-up, then periodic ALIGN insertion in READY.
module faux_sata_host_phy #(
  parameter int unsigned RESET_CYCLES   = 4,
  parameter int unsigned WAKE_CYCLES    = 4,
  parameter int unsigned INIT_TIMEOUT   = 1000,
  parameter int unsigned ALIGN_TIMEOUT  = 100,
  parameter int unsigned ALIGN_INTERVAL = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        comm_reset_req,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_is_k,
  input  logic        rx_is_elec_idle,
  input  logic        comm_init_detect,
  input  logic        comm_wake_detect,
  output logic [31:0] tx_dout,
  output logic        tx_is_k,
  output logic        tx_set_elec_idle,
  output logic        tx_comm_reset,
  output logic        tx_comm_wake,
  output logic        rx_byte_is_aligned,
  output logic [3:0]  lax_state,
  output logic        phy_ready
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] DIALTONE   = 32'h4A4A4A4A;

  localparam int unsigned TMR_MAX = (INIT_TIMEOUT > ALIGN_TIMEOUT) ? INIT_TIMEOUT : ALIGN_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned OOB_MAX = (RESET_CYCLES > WAKE_CYCLES) ? RESET_CYCLES : WAKE_CYCLES;
  localparam int unsigned OOB_W   = (OOB_MAX < 2) ? 1 : $clog2(OOB_MAX + 1);
  localparam int unsigned ACNT_W  = 8;

  typedef enum logic [3:0] {
    IDLE                  = 4'd0,
    SEND_RESET            = 4'd1,
    WAIT_FOR_INIT         = 4'd2,
    WAIT_FOR_NO_INIT      = 4'd3,
    SEND_WAKE             = 4'd4,
    WAIT_FOR_WAKE         = 4'd5,
    WAIT_FOR_NO_WAKE      = 4'd6,
    SEND_DIALTONE         = 4'd7,
    SEND_ALIGN            = 4'd8,
    READY                 = 4'd9,
    SEND_FIRST_ALIGNMENT  = 4'd10,
    SEND_SECOND_ALIGNMENT = 4'd11
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [OOB_W-1:0]    oob_cnt_q, oob_cnt_d;
  logic [ACNT_W-1:0]   align_cnt_q, align_cnt_d;
  logic [31:0]         tx_dout_q, tx_dout_d;
  logic                tx_is_k_q, tx_is_k_d;
  logic                tx_set_elec_idle_q, tx_set_elec_idle_d;
  logic                tx_comm_reset_q, tx_comm_reset_d;
  logic                tx_comm_wake_q, tx_comm_wake_d;
  logic                rx_byte_is_aligned_q, rx_byte_is_aligned_d;

  logic align_detected;
  logic non_align_k;
  logic link_active;
  logic unused_rx_elec_idle;

  assign unused_rx_elec_idle = rx_is_elec_idle;
  assign align_detected = (rx_is_k != 4'b0) && (rx_din == PRIM_ALIGN);
  assign non_align_k    = (rx_is_k != 4'b0) && (rx_din != PRIM_ALIGN);
  assign link_active    = (state_q >= SEND_DIALTONE) && (state_q <= SEND_SECOND_ALIGNMENT);

  // Next state and counters, then outputs derived from the state being entered
  always_comb begin
    state_d              = state_q;
    timer_d              = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;
    oob_cnt_d            = oob_cnt_q;
    align_cnt_d          = align_cnt_q;
    tx_dout_d            = '0;
    tx_is_k_d            = 1'b0;
    tx_set_elec_idle_d   = 1'b1;
    tx_comm_reset_d      = 1'b0;
    tx_comm_wake_d       = 1'b0;
    rx_byte_is_aligned_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d     = SEND_RESET;
        timer_d     = '0;
        oob_cnt_d   = '0;
        align_cnt_d = '0;
      end
      SEND_RESET: begin
        if (oob_cnt_q == OOB_W'(RESET_CYCLES - 1)) begin
          state_d   = WAIT_FOR_INIT;
          timer_d   = TMR_W'(INIT_TIMEOUT);
          oob_cnt_d = '0;
        end else begin
          oob_cnt_d = oob_cnt_q + OOB_W'(1);
        end
      end
      WAIT_FOR_INIT: begin
        if (comm_init_detect) begin
          state_d = WAIT_FOR_NO_INIT;
        end else if (timer_q == '0) begin
          state_d   = SEND_RESET;
          oob_cnt_d = '0;
        end
      end
      WAIT_FOR_NO_INIT: begin
        if (!comm_init_detect) begin
          state_d   = SEND_WAKE;
          oob_cnt_d = '0;
        end
      end
      SEND_WAKE: begin
        if (oob_cnt_q == OOB_W'(WAKE_CYCLES - 1)) begin
          state_d   = WAIT_FOR_WAKE;
          timer_d   = TMR_W'(INIT_TIMEOUT);
          oob_cnt_d = '0;
        end else begin
          oob_cnt_d = oob_cnt_q + OOB_W'(1);
        end
      end
      WAIT_FOR_WAKE: begin
        if (comm_wake_detect) begin
          state_d = WAIT_FOR_NO_WAKE;
        end else if (timer_q == '0) begin
          state_d   = SEND_RESET;
          oob_cnt_d = '0;
        end
      end
      WAIT_FOR_NO_WAKE: begin
        if (!comm_wake_detect) begin
          state_d = SEND_DIALTONE;
          timer_d = TMR_W'(ALIGN_TIMEOUT);
        end
      end
      SEND_DIALTONE: begin
        if (align_detected) begin
          state_d = SEND_ALIGN;
          timer_d = TMR_W'(ALIGN_TIMEOUT);
        end else if (timer_q == '0) begin
          state_d   = SEND_RESET;
          oob_cnt_d = '0;
        end
      end
      SEND_ALIGN: begin
        if (non_align_k) begin
          state_d     = READY;
          align_cnt_d = '0;
        end else if (timer_q == '0) begin
          state_d   = SEND_RESET;
          oob_cnt_d = '0;
        end
      end
      READY: begin
        // The READY cycle that sends the first of three ALIGNs hands off to the alignment states
        if (align_cnt_q == ACNT_W'(ALIGN_INTERVAL - 3)) begin
          state_d = SEND_FIRST_ALIGNMENT;
        end
        align_cnt_d = align_cnt_q + ACNT_W'(1);
      end
      SEND_FIRST_ALIGNMENT: begin
        state_d     = SEND_SECOND_ALIGNMENT;
        align_cnt_d = align_cnt_q + ACNT_W'(1);
      end
      SEND_SECOND_ALIGNMENT: begin
        state_d     = READY;
        align_cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (link_active && comm_init_detect) begin
      state_d     = WAIT_FOR_NO_INIT;
      align_cnt_d = '0;
    end

    if (comm_reset_req && (state_q != IDLE) && (state_q != SEND_RESET)) begin
      state_d     = SEND_RESET;
      timer_d     = '0;
      oob_cnt_d   = '0;
      align_cnt_d = '0;
    end

    case (state_d)
      SEND_RESET: tx_comm_reset_d = 1'b1;
      SEND_WAKE:  tx_comm_wake_d  = 1'b1;
      SEND_DIALTONE: begin
        tx_set_elec_idle_d = 1'b0;
        tx_dout_d          = DIALTONE;
      end
      SEND_ALIGN, SEND_FIRST_ALIGNMENT, SEND_SECOND_ALIGNMENT: begin
        tx_set_elec_idle_d   = 1'b0;
        tx_dout_d            = PRIM_ALIGN;
        tx_is_k_d            = 1'b1;
        rx_byte_is_aligned_d = 1'b1;
      end
      READY: begin
        tx_set_elec_idle_d   = 1'b0;
        tx_dout_d            = (align_cnt_d == ACNT_W'(ALIGN_INTERVAL - 3)) ? PRIM_ALIGN : PRIM_SYNC;
        tx_is_k_d            = 1'b1;
        rx_byte_is_aligned_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      timer_q              <= '0;
      oob_cnt_q            <= '0;
      align_cnt_q          <= '0;
      tx_dout_q            <= '0;
      tx_is_k_q            <= 1'b0;
      tx_set_elec_idle_q   <= 1'b1;
      tx_comm_reset_q      <= 1'b0;
      tx_comm_wake_q       <= 1'b0;
      rx_byte_is_aligned_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      timer_q              <= timer_d;
      oob_cnt_q            <= oob_cnt_d;
      align_cnt_q          <= align_cnt_d;
      tx_dout_q            <= tx_dout_d;
      tx_is_k_q            <= tx_is_k_d;
      tx_set_elec_idle_q   <= tx_set_elec_idle_d;
      tx_comm_reset_q      <= tx_comm_reset_d;
      tx_comm_wake_q       <= tx_comm_wake_d;
      rx_byte_is_aligned_q <= rx_byte_is_aligned_d;
    end
  end

  assign tx_dout            = tx_dout_q;
  assign tx_is_k            = tx_is_k_q;
  assign tx_set_elec_idle   = tx_set_elec_idle_q;
  assign tx_comm_reset      = tx_comm_reset_q;
  assign tx_comm_wake       = tx_comm_wake_q;
  assign rx_byte_is_aligned = rx_byte_is_aligned_q;
  assign lax_state          = state_q;
  assign phy_ready          = (state_q == READY);

endmodule

// File: tb/tb_faux_sata_host_phy.sv
// Randomized bench for faux_sata_host_phy: a scripted device with random response gaps,
// checked against per-cycle expectations built from the link bring-up rules.
module tb_faux_sata_host_phy;

  localparam int unsigned RC = 4;
  localparam int unsigned WC = 4;
  localparam int unsigned IT = 1000;
  localparam int unsigned AT = 100;
  localparam int unsigned AI = 256;

  localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_P  = 32'hB5B5957C;
  localparam logic [31:0] DIAL_P  = 32'h4A4A4A4A;

  localparam logic [3:0] S_IDLE = 4'd0, S_RST = 4'd1, S_WINIT = 4'd2, S_WNOINIT = 4'd3;
  localparam logic [3:0] S_WAKE = 4'd4, S_WWAKE = 4'd5, S_WNOWAKE = 4'd6, S_DIAL = 4'd7;
  localparam logic [3:0] S_ALIGN = 4'd8, S_READY = 4'd9, S_FIRST = 4'd10, S_SECOND = 4'd11;

  logic        clk;
  logic        rst;
  logic        comm_reset_req;
  logic [31:0] rx_din;
  logic [3:0]  rx_is_k;
  logic        rx_is_elec_idle;
  logic        comm_init_detect;
  logic        comm_wake_detect;
  logic [31:0] tx_dout;
  logic        tx_is_k;
  logic        tx_set_elec_idle;
  logic        tx_comm_reset;
  logic        tx_comm_wake;
  logic        rx_byte_is_aligned;
  logic [3:0]  lax_state;
  logic        phy_ready;

  int vectors;
  int miscompares;
  int rx_mode;

  faux_sata_host_phy #(
    .RESET_CYCLES  (RC),
    .WAKE_CYCLES   (WC),
    .INIT_TIMEOUT  (IT),
    .ALIGN_TIMEOUT (AT),
    .ALIGN_INTERVAL(AI)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .comm_reset_req    (comm_reset_req),
    .rx_din            (rx_din),
    .rx_is_k           (rx_is_k),
    .rx_is_elec_idle   (rx_is_elec_idle),
    .comm_init_detect  (comm_init_detect),
    .comm_wake_detect  (comm_wake_detect),
    .tx_dout           (tx_dout),
    .tx_is_k           (tx_is_k),
    .tx_set_elec_idle  (tx_set_elec_idle),
    .tx_comm_reset     (tx_comm_reset),
    .tx_comm_wake      (tx_comm_wake),
    .rx_byte_is_aligned(rx_byte_is_aligned),
    .lax_state         (lax_state),
    .phy_ready         (phy_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {state, comm_reset, comm_wake, elec_idle, byte_aligned, phy_ready} implied by a state
  function automatic logic [8:0] exp_flags(input logic [3:0] st);
    return {st, st == S_RST, st == S_WAKE, st <= S_WNOWAKE, st >= S_ALIGN, st == S_READY};
  endfunction

  function automatic logic [8:0] obs_flags();
    return {lax_state, tx_comm_reset, tx_comm_wake, tx_set_elec_idle, rx_byte_is_aligned, phy_ready};
  endfunction

  // 0: random data without K; 1: ALIGN primitive; 2: some non-ALIGN K dword; 3: anything
  task automatic drive_rx(input int mode);
    logic [31:0] d;
    case (mode)
      0: begin rx_din = $urandom; rx_is_k = 4'b0; end
      1: begin rx_din = ALIGN_P; rx_is_k = 4'($urandom_range(1, 15)); end
      2: begin
        d = $urandom;
        if (d == ALIGN_P) d = SYNC_P;
        rx_din = d;
        rx_is_k = 4'($urandom_range(1, 15));
      end
      default: begin rx_din = $urandom; rx_is_k = 4'($urandom); end
    endcase
    rx_is_elec_idle = 1'($urandom);
  endtask

  task automatic run(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      drive_rx(rx_mode);
      step();
      check($sformatf("state%0d.flags", st), 64'(obs_flags()), 64'(exp_flags(st)));
      if (st == S_DIAL)
        check("dialtone.tx", 64'({tx_is_k, tx_dout}), 64'({1'b0, DIAL_P}));
      else if (st == S_ALIGN)
        check("send_align.tx", 64'({tx_is_k, tx_dout}), 64'({1'b1, ALIGN_P}));
    end
  endtask

  // p counts cycles since READY was entered; ALIGNs occupy the last 3 slots of each interval
  task automatic ready_phase(input int n);
    int ph;
    logic [3:0] st;
    for (int p = 0; p < n; p++) begin
      drive_rx(p == 0 ? 2 : 3);
      step();
      ph = p % int'(AI);
      st = (ph == int'(AI) - 2) ? S_FIRST : (ph == int'(AI) - 1) ? S_SECOND : S_READY;
      check("ready.flags", 64'(obs_flags()), 64'(exp_flags(st)));
      check("ready.tx", 64'({tx_is_k, tx_dout}),
            64'({1'b1, (ph >= int'(AI) - 3) ? ALIGN_P : SYNC_P}));
    end
  endtask

  task automatic init_phase();
    comm_init_detect = 1'b0;
    run(S_WINIT, $urandom_range(1, 40));
    comm_init_detect = 1'b1;
    run(S_WNOINIT, $urandom_range(1, 6));
    comm_init_detect = 1'b0;
  endtask

  task automatic wake_to_ready();
    run(S_WAKE, WC);
    run(S_WWAKE, $urandom_range(1, 40));
    comm_wake_detect = 1'b1;
    run(S_WNOWAKE, $urandom_range(1, 6));
    comm_wake_detect = 1'b0;
    rx_mode = 0;
    run(S_DIAL, $urandom_range(1, 30));
    rx_mode = 1;
    run(S_ALIGN, $urandom_range(1, 30));
    rx_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".flags"}, 64'(obs_flags()), 64'(exp_flags(S_IDLE)));
    check({tag, ".tx"}, 64'({tx_is_k, tx_dout}), 64'(0));
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rx_mode = 0;
    rst = 1'b1;
    comm_reset_req = 1'b0;
    comm_init_detect = 1'b0;
    comm_wake_detect = 1'b0;
    rx_din = '0;
    rx_is_k = '0;
    rx_is_elec_idle = 1'b1;
    step();
    step();
    check_reset_outputs("reset");

    // Silent device: COMRESET, full timeout, COMRESET again, then device answers
    rst = 1'b0;
    run(S_RST, RC);
    run(S_WINIT, IT + 1);
    run(S_RST, RC);
    init_phase();
    wake_to_ready();
    ready_phase(2 * AI + 10);

    // Device-initiated reset from READY, then re-train
    comm_init_detect = 1'b1;
    run(S_WNOINIT, 3);
    comm_init_detect = 1'b0;
    wake_to_ready();
    ready_phase($urandom_range(5, 300));

    // Host link requests COMRESET from READY
    comm_reset_req = 1'b1;
    run(S_RST, 1);
    comm_reset_req = 1'b0;
    run(S_RST, RC - 1);
    init_phase();

    // Device never answers COMWAKE
    run(S_WAKE, WC);
    run(S_WWAKE, IT + 1);
    run(S_RST, RC);
    init_phase();

    // Device never sends ALIGN during dialtone
    run(S_WAKE, WC);
    run(S_WWAKE, $urandom_range(1, 20));
    comm_wake_detect = 1'b1;
    run(S_WNOWAKE, 2);
    comm_wake_detect = 1'b0;
    rx_mode = 0;
    run(S_DIAL, AT + 1);
    run(S_RST, RC);
    init_phase();

    // Reset request wins over a simultaneous device COMINIT level
    run(S_WAKE, WC);
    run(S_WWAKE, 3);
    comm_reset_req = 1'b1;
    comm_init_detect = 1'b1;
    run(S_RST, 1);
    comm_reset_req = 1'b0;
    comm_init_detect = 1'b0;
    run(S_RST, RC - 1);
    init_phase();

    // Reset in the middle of COMWAKE
    run(S_WAKE, 2);
    rst = 1'b1;
    step();
    check_reset_outputs("rst_mid_wake");
    rst = 1'b0;
    run(S_RST, RC);

    // Several randomized bring-ups, each ending in a reset taken from READY
    for (int k = 0; k < 3; k++) begin
      init_phase();
      wake_to_ready();
      ready_phase($urandom_range(1, 600));
      rst = 1'b1;
      step();
      check_reset_outputs("rst_in_ready");
      rst = 1'b0;
      run(S_RST, RC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
